// File: rtl/fetch_block_scan_pkg.sv
// Shared types and RISC-V opcode constants for the fetch block pre-decoder.
package fetch_block_scan_pkg;

    typedef enum logic [2:0] {
        CF_NONE     = 3'd0,
        CF_BRANCH   = 3'd1,
        CF_JUMP     = 3'd2,
        CF_JALR     = 3'd3,
        CF_RETURN   = 3'd4,
        CF_CALL     = 3'd5,
        CF_CORETURN = 3'd6
    } cf_type_e;

    localparam logic [6:0] OpcodeBranch = 7'b1100011;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;
    localparam logic [6:0] OpcodeSystem = 7'b1110011;

    localparam logic [1:0] OpcodeC1 = 2'b01;
    localparam logic [1:0] OpcodeC2 = 2'b10;

    localparam logic [2:0] OpcodeC1J         = 3'b101;
    localparam logic [2:0] OpcodeC1Jal       = 3'b001;
    localparam logic [2:0] OpcodeC1Beqz      = 3'b110;
    localparam logic [2:0] OpcodeC1Bnez      = 3'b111;
    localparam logic [2:0] OpcodeC2JalrMvAdd = 3'b100;

    localparam logic [31:0] InstrMret = 32'h30200073;
    localparam logic [31:0] InstrSret = 32'h10200073;
    localparam logic [31:0] InstrUret = 32'h00200073;

    // x1 (ra) and x5 (t0) are the link registers for return-stack hints
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/fetch_block_scan_slot_predecode.sv
// Combinational control-flow classifier for one instruction slot.
module slot_predecode #(
    parameter int VLEN = 64,
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic            is_rvc,
    output logic [2:0]      cf_type,
    output logic [VLEN-1:0] imm
);
    import fetch_block_scan_pkg::*;

    cf_type_e        cf;
    logic            xret;
    logic            rs1_link;
    logic            rd_link;
    logic [VLEN-1:0] imm_j;
    logic [VLEN-1:0] imm_b;
    logic [VLEN-1:0] imm_cj;
    logic [VLEN-1:0] imm_cb;

    assign rs1_link = is_link_reg(instr[19:15]);
    assign rd_link  = is_link_reg(instr[11:7]);

    assign imm_j  = {{(VLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_b  = {{(VLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_cj = {{(VLEN-11){instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                     instr[2], instr[11], instr[5:3], 1'b0};
    assign imm_cb = {{(VLEN-8){instr[12]}}, instr[6:5], instr[2], instr[11:10],
                     instr[4:3], 1'b0};

    always_comb begin
        cf   = CF_NONE;
        xret = 1'b0;
        if (is_rvc) begin
            if (instr[1:0] == OpcodeC1) begin
                case (instr[15:13])
                    OpcodeC1J:    cf = CF_JUMP;
                    OpcodeC1Jal:  cf = (XLEN == 32) ? CF_CALL : CF_NONE;
                    OpcodeC1Beqz: cf = CF_BRANCH;
                    OpcodeC1Bnez: cf = CF_BRANCH;
                    default:      cf = CF_NONE;
                endcase
            end else if (instr[1:0] == OpcodeC2 && instr[15:13] == OpcodeC2JalrMvAdd &&
                         instr[11:7] != 5'd0 && instr[6:2] == 5'd0) begin
                // bit 12 separates c.jalr from c.jr
                if (instr[12]) begin
                    cf = CF_CALL;
                end else begin
                    cf = is_link_reg(instr[11:7]) ? CF_RETURN : CF_JALR;
                end
            end
        end else begin
            case (instr[6:0])
                OpcodeBranch: cf = CF_BRANCH;
                OpcodeJal:    cf = rd_link ? CF_CALL : CF_JUMP;
                OpcodeJalr: begin
                    if (rs1_link && rd_link && instr[19:15] != instr[11:7]) begin
                        cf = CF_CORETURN;
                    end else if (rs1_link && !rd_link) begin
                        cf = CF_RETURN;
                    end else if (rd_link && !rs1_link) begin
                        cf = CF_CALL;
                    end else begin
                        cf = CF_JALR;
                    end
                end
                OpcodeSystem: begin
                    if (instr == InstrMret || instr == InstrSret || instr == InstrUret) begin
                        cf   = CF_JUMP;
                        xret = 1'b1;
                    end
                end
                default: cf = CF_NONE;
            endcase
        end
    end

    always_comb begin
        cf_type = cf;
        if (cf == CF_NONE || xret) begin
            imm = '0;
        end else if (is_rvc) begin
            imm = instr[14] ? imm_cb : imm_cj;
        end else begin
            imm = instr[3] ? imm_j : imm_b;
        end
    end

endmodule

// File: rtl/fetch_block_scan.sv
// Registered fetch-block pre-decoder: finds instruction starts (including
// block-straddling 32-bit instructions), classifies them and registers the result.
module fetch_block_scan #(
    parameter int FETCH_WIDTH = 64,
    parameter int VLEN        = 64,
    parameter int XLEN        = 64,
    localparam int NR_SLOTS   = FETCH_WIDTH / 16,
    localparam int SLOT_W     = $clog2(NR_SLOTS),
    localparam int BLK_OFF    = $clog2(FETCH_WIDTH / 8)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [VLEN-1:0]          addr_i,
    input  logic [FETCH_WIDTH-1:0]   data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [NR_SLOTS-1:0]      instr_valid_o,
    output logic [NR_SLOTS*32-1:0]   instr_o,
    output logic [NR_SLOTS-1:0]      is_rvc_o,
    output logic [NR_SLOTS*3-1:0]    cf_type_o,
    output logic [NR_SLOTS*VLEN-1:0] imm_o,
    output logic [NR_SLOTS*VLEN-1:0] addr_o,
    output logic [SLOT_W-1:0]        first_cf_o,
    output logic                     has_cf_o
);
    import fetch_block_scan_pkg::*;

    logic [NR_SLOTS-1:0][15:0] parcel;
    logic [VLEN-1:0]           blk_base;
    logic [SLOT_W-1:0]         start_slot;
    logic                      carry_hit;
    logic                      accept;

    logic                          carry_q;
    logic [15:0]                   carry_half_q;
    logic [VLEN-1:0]               carry_addr_q;
    logic                          next_carry;
    logic [15:0]                   next_carry_half;
    logic [VLEN-1:0]               next_carry_addr;

    logic                          skip;
    logic [NR_SLOTS-1:0]           walk_valid;
    logic [NR_SLOTS-1:0]           walk_rvc;
    logic [NR_SLOTS-1:0][31:0]     walk_instr;
    logic [NR_SLOTS-1:0][VLEN-1:0] walk_addr;

    logic [NR_SLOTS-1:0][2:0]      dec_cf;
    logic [NR_SLOTS-1:0][VLEN-1:0] dec_imm;
    logic [NR_SLOTS-1:0][2:0]      slot_cf;
    logic [NR_SLOTS-1:0][VLEN-1:0] slot_imm;
    logic [NR_SLOTS-1:0][VLEN-1:0] slot_addr;
    logic [SLOT_W-1:0]             first_cf_d;
    logic                          has_cf_d;

    logic                          valid_q;
    logic [NR_SLOTS-1:0]           instr_valid_q;
    logic [NR_SLOTS-1:0]           is_rvc_q;
    logic [NR_SLOTS-1:0][31:0]     instr_q;
    logic [NR_SLOTS-1:0][2:0]      cf_type_q;
    logic [NR_SLOTS-1:0][VLEN-1:0] imm_q;
    logic [NR_SLOTS-1:0][VLEN-1:0] addr_q;
    logic [SLOT_W-1:0]             first_cf_q;
    logic                          has_cf_q;

    assign parcel     = data_i;
    assign blk_base   = {addr_i[VLEN-1:BLK_OFF], {BLK_OFF{1'b0}}};
    assign start_slot = addr_i[BLK_OFF-1:1];
    assign carry_hit  = carry_q && (addr_i == carry_addr_q + VLEN'(2));
    assign ready_o    = ~valid_q | ready_i;
    assign accept     = valid_i & ready_o;

    // Walk the parcels from the start slot; the upper half of a 32-bit
    // instruction is skipped, and a 32-bit start in the last parcel is parked
    // in the carry registers for the next sequential block.
    always_comb begin
        walk_valid      = '0;
        walk_rvc        = '0;
        walk_instr      = '0;
        walk_addr       = '0;
        next_carry      = 1'b0;
        next_carry_half = carry_half_q;
        next_carry_addr = carry_addr_q;
        skip            = 1'b0;
        for (int p = 0; p < NR_SLOTS; p++) begin
            if (carry_hit && p == 0) begin
                walk_valid[0] = 1'b1;
                walk_instr[0] = {parcel[0], carry_half_q};
                walk_addr[0]  = carry_addr_q;
            end else if (!skip && p >= int'(start_slot)) begin
                if (parcel[p][1:0] != 2'b11) begin
                    walk_valid[p] = 1'b1;
                    walk_rvc[p]   = 1'b1;
                    walk_instr[p] = {16'h0000, parcel[p]};
                    walk_addr[p]  = blk_base + VLEN'(2 * p);
                end else if (p + 1 < NR_SLOTS) begin
                    walk_valid[p] = 1'b1;
                    walk_instr[p] = {parcel[(p + 1) % NR_SLOTS], parcel[p]};
                    walk_addr[p]  = blk_base + VLEN'(2 * p);
                    skip          = 1'b1;
                end else begin
                    next_carry      = 1'b1;
                    next_carry_half = parcel[p];
                    next_carry_addr = blk_base + VLEN'(2 * p);
                end
            end else begin
                skip = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NR_SLOTS; g++) begin : g_slot
        slot_predecode #(
            .VLEN (VLEN),
            .XLEN (XLEN)
        ) u_slot_predecode (
            .instr   (walk_instr[g]),
            .is_rvc  (walk_rvc[g]),
            .cf_type (dec_cf[g]),
            .imm     (dec_imm[g])
        );

        assign slot_cf[g]   = walk_valid[g] ? dec_cf[g]    : 3'(CF_NONE);
        assign slot_imm[g]  = walk_valid[g] ? dec_imm[g]   : '0;
        assign slot_addr[g] = walk_valid[g] ? walk_addr[g] : '0;
    end

    // Lowest-index slot with a control-flow instruction wins
    always_comb begin
        first_cf_d = '0;
        has_cf_d   = 1'b0;
        for (int p = NR_SLOTS - 1; p >= 0; p--) begin
            if (slot_cf[p] != 3'(CF_NONE)) begin
                first_cf_d = SLOT_W'(p);
                has_cf_d   = 1'b1;
            end
        end
    end

    // Output and carry registers only move on an input handshake; flush
    // overrides everything and a bare downstream accept just drains valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q       <= 1'b0;
            instr_valid_q <= '0;
            is_rvc_q      <= '0;
            instr_q       <= '0;
            cf_type_q     <= '0;
            imm_q         <= '0;
            addr_q        <= '0;
            first_cf_q    <= '0;
            has_cf_q      <= 1'b0;
            carry_q       <= 1'b0;
            carry_half_q  <= '0;
            carry_addr_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
        end else if (accept) begin
            valid_q       <= 1'b1;
            instr_valid_q <= walk_valid;
            is_rvc_q      <= walk_rvc;
            instr_q       <= walk_instr;
            cf_type_q     <= slot_cf;
            imm_q         <= slot_imm;
            addr_q        <= slot_addr;
            first_cf_q    <= first_cf_d;
            has_cf_q      <= has_cf_d;
            carry_q       <= next_carry;
            carry_half_q  <= next_carry_half;
            carry_addr_q  <= next_carry_addr;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o       = valid_q;
    assign instr_valid_o = instr_valid_q;
    assign is_rvc_o      = is_rvc_q;
    assign instr_o       = instr_q;
    assign cf_type_o     = cf_type_q;
    assign imm_o         = imm_q;
    assign addr_o        = addr_q;
    assign first_cf_o    = first_cf_q;
    assign has_cf_o      = has_cf_q;

endmodule

// File: tb/tb_fetch_block_scan.sv
// Scoreboard bench for fetch_block_scan: stimulus pushes expected bundles,
// a monitor pops and compares each bundle the DUT hands downstream.
module tb_fetch_block_scan;

    logic          clk;
    logic          rst;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [63:0]   addr_i;
    logic [63:0]   data_i;
    logic          valid_o;
    logic          ready_i;
    logic [3:0]    instr_valid_o;
    logic [127:0]  instr_o;
    logic [3:0]    is_rvc_o;
    logic [11:0]   cf_type_o;
    logic [255:0]  imm_o;
    logic [255:0]  addr_o;
    logic [1:0]    first_cf_o;
    logic          has_cf_o;

    logic          ready_o_32;
    logic          valid_o_32;
    logic [3:0]    instr_valid_o_32;
    logic [127:0]  instr_o_32;
    logic [3:0]    is_rvc_o_32;
    logic [11:0]   cf_type_o_32;
    logic [255:0]  imm_o_32;
    logic [255:0]  addr_o_32;
    logic [1:0]    first_cf_o_32;
    logic          has_cf_o_32;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           id;
        logic [3:0]   v;
        logic [3:0]   rvc;
        logic [127:0] instr;
        logic [11:0]  cf;
        logic [255:0] imm;
        logic [255:0] addr;
        logic [1:0]   first;
        logic         has;
    } exp_t;

    exp_t e;
    exp_t exp_q[$];
    int   next_id = 0;

    fetch_block_scan #(.FETCH_WIDTH(64), .VLEN(64), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .addr_i(addr_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .is_rvc_o(is_rvc_o),
        .cf_type_o(cf_type_o), .imm_o(imm_o), .addr_o(addr_o),
        .first_cf_o(first_cf_o), .has_cf_o(has_cf_o)
    );

    fetch_block_scan #(.FETCH_WIDTH(64), .VLEN(64), .XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o_32),
        .addr_i(addr_i), .data_i(data_i), .valid_o(valid_o_32), .ready_i(ready_i),
        .instr_valid_o(instr_valid_o_32), .instr_o(instr_o_32), .is_rvc_o(is_rvc_o_32),
        .cf_type_o(cf_type_o_32), .imm_o(imm_o_32), .addr_o(addr_o_32),
        .first_cf_o(first_cf_o_32), .has_cf_o(has_cf_o_32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] blk(input logic [15:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic clear_exp(input logic [1:0] first, input logic has);
        e       = '{default: '0};
        e.first = first;
        e.has   = has;
    endtask

    task automatic set_slot(input int p, input logic rvc, input logic [31:0] ins,
                            input logic [2:0] cf, input logic [63:0] imm, input logic [63:0] a);
        e.v[p]            = 1'b1;
        e.rvc[p]          = rvc;
        e.instr[p*32 +: 32] = ins;
        e.cf[p*3 +: 3]    = cf;
        e.imm[p*64 +: 64] = imm;
        e.addr[p*64 +: 64] = a;
    endtask

    // Block whose last parcel opens a 32-bit ret, preceded by three c.nop
    task automatic exp_straddle_first(input logic [63:0] base);
        clear_exp(2'd0, 1'b0);
        set_slot(0, 1'b1, 32'h1, 3'd0, 64'd0, base);
        set_slot(1, 1'b1, 32'h1, 3'd0, 64'd0, base + 64'd2);
        set_slot(2, 1'b1, 32'h1, 3'd0, 64'd0, base + 64'd4);
    endtask

    task automatic exp_straddle_second(input logic [63:0] base);
        clear_exp(2'd0, 1'b1);
        set_slot(0, 1'b0, 32'h00008067, 3'd4, 64'd0, base + 64'd6);
        set_slot(1, 1'b1, 32'h1, 3'd0, 64'd0, base + 64'd10);
        set_slot(2, 1'b1, 32'h1, 3'd0, 64'd0, base + 64'd12);
        set_slot(3, 1'b1, 32'h1, 3'd0, 64'd0, base + 64'd14);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d);
        int guard;
        guard   = 0;
        addr_i  = a;
        data_i  = d;
        valid_i = 1'b1;
        while (!ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got ready_o=0 expected ready_o=1 within 50 cycles");
        end else begin
            e.id = next_id++;
            exp_q.push_back(e);
        end
        tick();
        valid_i = 1'b0;
    endtask

    // Monitor: every downstream handshake must match the oldest expected bundle
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (!rst && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got valid_o=1 expected no output");
                end else begin
                    ex = exp_q.pop_front();
                    checkOutput($sformatf("out%0d.instr_valid", ex.id), 256'(instr_valid_o), 256'(ex.v));
                    checkOutput($sformatf("out%0d.is_rvc", ex.id), 256'(is_rvc_o), 256'(ex.rvc));
                    checkOutput($sformatf("out%0d.instr", ex.id), 256'(instr_o), 256'(ex.instr));
                    checkOutput($sformatf("out%0d.cf_type", ex.id), 256'(cf_type_o), 256'(ex.cf));
                    checkOutput($sformatf("out%0d.imm", ex.id), imm_o, ex.imm);
                    checkOutput($sformatf("out%0d.addr", ex.id), addr_o, ex.addr);
                    checkOutput($sformatf("out%0d.has_cf", ex.id), 256'(has_cf_o), 256'(ex.has));
                    if (ex.has) begin
                        checkOutput($sformatf("out%0d.first_cf", ex.id), 256'(first_cf_o), 256'(ex.first));
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        addr_i  = '0;
        data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset.valid_o", 256'(valid_o), 256'(0));
        checkOutput("reset.ready_o", 256'(ready_o), 256'(1));
        checkOutput("reset.instr_valid", 256'(instr_valid_o), 256'(0));
        checkOutput("reset.has_cf", 256'(has_cf_o), 256'(0));

        $display("[TB] mixed block");
        clear_exp(2'd0, 1'b1);
        set_slot(0, 1'b1, 32'h0000A001, 3'd2, 64'd0, 64'h80000000);
        set_slot(1, 1'b0, 32'h008000EF, 3'd5, 64'd8, 64'h80000002);
        set_slot(3, 1'b1, 32'h00000001, 3'd0, 64'd0, 64'h80000006);
        applyStimulus(64'h80000000, blk(16'hA001, 16'h00EF, 16'h0080, 16'h0001));

        $display("[TB] straddle");
        exp_straddle_first(64'h80000000);
        applyStimulus(64'h80000000, blk(16'h0001, 16'h0001, 16'h0001, 16'h8067));
        exp_straddle_second(64'h80000000);
        applyStimulus(64'h80000008, blk(16'h0000, 16'h0001, 16'h0001, 16'h0001));

        $display("[TB] redirect drops carry");
        exp_straddle_first(64'h80001000);
        applyStimulus(64'h80001000, blk(16'h0001, 16'h0001, 16'h0001, 16'h8067));
        clear_exp(2'd2, 1'b1);
        set_slot(2, 1'b1, 32'h0000A001, 3'd2, 64'd0, 64'h80001004);
        set_slot(3, 1'b1, 32'h00000001, 3'd0, 64'd0, 64'h80001006);
        applyStimulus(64'h80001004, blk(16'h0000, 16'h0000, 16'hA001, 16'h0001));

        $display("[TB] branches and return");
        clear_exp(2'd0, 1'b1);
        set_slot(0, 1'b0, 32'hFE000EE3, 3'd1, 64'hFFFFFFFFFFFFFFFC, 64'h80005000);
        set_slot(2, 1'b1, 32'h0000C019, 3'd1, 64'd6, 64'h80005004);
        set_slot(3, 1'b1, 32'h00008082, 3'd4, 64'h40, 64'h80005006);
        applyStimulus(64'h80005000, blk(16'h0EE3, 16'hFE00, 16'hC019, 16'h8082));

        $display("[TB] backpressure");
        tick();
        ready_i = 1'b0;
        exp_straddle_first(64'h80002000);
        applyStimulus(64'h80002000, blk(16'h0001, 16'h0001, 16'h0001, 16'h8067));
        addr_i  = 64'h80002008;
        data_i  = blk(16'h0000, 16'h0001, 16'h0001, 16'h0001);
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall%0d.ready_o", i), 256'(ready_o), 256'(0));
            checkOutput($sformatf("stall%0d.valid_o", i), 256'(valid_o), 256'(1));
            checkOutput($sformatf("stall%0d.instr_valid", i), 256'(instr_valid_o), 256'(4'b0111));
            checkOutput($sformatf("stall%0d.addr0", i), 256'(addr_o[63:0]), 256'(64'h80002000));
            tick();
        end
        exp_straddle_second(64'h80002000);
        e.id = next_id++;
        exp_q.push_back(e);
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checkOutput("release.valid_o", 256'(valid_o), 256'(1));
        checkOutput("release.addr0", 256'(addr_o[63:0]), 256'(64'h80002006));

        $display("[TB] flush");
        exp_straddle_first(64'h80003000);
        applyStimulus(64'h80003000, blk(16'h0001, 16'h0001, 16'h0001, 16'h8067));
        addr_i  = 64'h80003008;
        data_i  = blk(16'h0000, 16'h0001, 16'h0001, 16'h0001);
        valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        checkOutput("flush.valid_o", 256'(valid_o), 256'(0));
        checkOutput("flush.ready_o", 256'(ready_o), 256'(1));
        clear_exp(2'd0, 1'b0);
        set_slot(0, 1'b1, 32'h00000000, 3'd0, 64'd0, 64'h80003008);
        set_slot(1, 1'b1, 32'h00000001, 3'd0, 64'd0, 64'h8000300A);
        set_slot(2, 1'b1, 32'h00000001, 3'd0, 64'd0, 64'h8000300C);
        set_slot(3, 1'b1, 32'h00000001, 3'd0, 64'd0, 64'h8000300E);
        applyStimulus(64'h80003008, blk(16'h0000, 16'h0001, 16'h0001, 16'h0001));

        $display("[TB] xret and c.jal");
        clear_exp(2'd0, 1'b1);
        set_slot(0, 1'b0, 32'h30200073, 3'd2, 64'd0, 64'h80004000);
        set_slot(2, 1'b1, 32'h00002001, 3'd0, 64'd0, 64'h80004004);
        set_slot(3, 1'b1, 32'h00000001, 3'd0, 64'd0, 64'h80004006);
        applyStimulus(64'h80004000, blk(16'h0073, 16'h3020, 16'h2001, 16'h0001));
        checkOutput("xlen32.cjal_cf", 256'(cf_type_o_32[8:6]), 256'(3'd5));
        checkOutput("xlen32.cjal_imm", 256'(imm_o_32[191:128]), 256'(64'd0));
        checkOutput("xlen32.xret_cf", 256'(cf_type_o_32[2:0]), 256'(3'd2));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending outputs expected 0", exp_q.size());
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
